cpu_player: RTL and testbench

- Computer opponent for the tug-of-war playfield. It is the driving end of the player-button interface that the light cells consume.
- Generates pseudo-random, single-cycle button presses. Press rate is set by a difficulty input.
- Output is a clean one-cycle pulse, separated by a cooldown, so it can replace a human's conditioned button (e.g. drive rightButton of the right edge and centre lights).
- Stops pressing once any player has won.

---
 rtl/cpu_player.sv | 70 +++++++
 tb/tb_cpu_player.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/cpu_player.sv
// cpu_player: computer opponent issuing LFSR-gated one-cycle button presses with cooldown.
//   clk        : system clock
//   Reset      : synchronous active-high reset
//   enable     : 1 = CPU player active
//   gameOver   : blocks new presses while high
//   difficulty : press threshold, a press fires when lfsr < difficulty on a tick
//   cpuButton  : one-cycle press pulse
//   pressCount : saturating count of presses since Reset
module cpu_player #(
    parameter int                LFSR_W   = 10,
    parameter logic [LFSR_W-1:0] SEED     = 10'h001,
    parameter int                TICK_DIV = 4,
    parameter int                COOLDOWN = 3
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              enable,
    input  logic              gameOver,
    input  logic [LFSR_W-1:0] difficulty,
    output logic              cpuButton,
    output logic [7:0]        pressCount
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int CW = COOLDOWN > 1 ? $clog2(COOLDOWN) : 1;
    typedef enum logic [1:0] {READY, PRESS, COOL} state_t;
    state_t            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [CW-1:0]     cool_q, cool_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              tick;
    always_comb begin
        // taps at bits 9 and 6 realise x^10+x^7+1
        lfsr_d  = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-4]};
        tick    = tick_q == TW'(TICK_DIV - 1);
        tick_d  = tick ? '0 : tick_q + 1'b1;
        state_d = state_q;
        cool_d  = cool_q;
        cnt_d   = (state_q == PRESS && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
        case (state_q)
            READY: state_d = (tick && enable && !gameOver && lfsr_q < difficulty) ? PRESS : READY;
            PRESS: begin
                state_d = COOL;
                cool_d  = CW'(COOLDOWN - 1);
            end
            COOL: begin
                state_d = cool_q == '0 ? READY : COOL;
                cool_d  = cool_q == '0 ? cool_q : cool_q - 1'b1;
            end
            default: state_d = READY;
        endcase
    end
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= READY;
            lfsr_q  <= SEED;
            tick_q  <= '0;
            cool_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            tick_q  <= tick_d;
            cool_q  <= cool_d;
            cnt_q   <= cnt_d;
        end
    end
    assign cpuButton  = state_q == PRESS;
    assign pressCount = cnt_q;
endmodule

// File: tb/tb_cpu_player.sv
// tb_cpu_player: randomized and directed checks of cpu_player against a cycle-indexed behavioural model.
module tb_cpu_player;
    localparam int        W    = 10;
    localparam int        TD   = 4;
    localparam int        CD   = 3;
    localparam logic [9:0] SEED = 10'h001;
    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       enable = 1'b0;
    logic       gameOver = 1'b0;
    logic [9:0] difficulty = '0;
    logic       cpuButton;
    logic [7:0] pressCount;
    int tests = 0;
    int fails = 0;
    cpu_player #(.LFSR_W(W), .SEED(SEED), .TICK_DIV(TD), .COOLDOWN(CD)) dut (
        .clk(clk), .Reset(Reset), .enable(enable), .gameOver(gameOver),
        .difficulty(difficulty), .cpuButton(cpuButton), .pressCount(pressCount)
    );
    always #5 clk = ~clk;
    // Model: cycles counted from reset release; a decision at cycle t presses at t+1
    // and the player is free to decide again from t+2+CD.
    logic [9:0] m_lfsr;
    int m_cyc, m_press_at, m_free, m_cnt;
    bit m_valid = 0;
    always @(posedge clk) begin
        if (Reset) begin
            m_lfsr = SEED; m_cyc = 0; m_press_at = -1; m_free = 0; m_cnt = 0; m_valid = 1;
        end else begin
            if (m_cyc == m_press_at && m_cnt < 255) m_cnt++;
            if (m_cyc % TD == TD - 1 && m_cyc >= m_free && enable && !gameOver && m_lfsr < difficulty) begin
                m_press_at = m_cyc + 1;
                m_free = m_cyc + 2 + CD;
            end
            m_lfsr = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
            m_cyc++;
        end
    end
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask
    int g_cyc = 0;
    int last_rise = -1;
    always @(negedge clk) begin
        g_cyc++;
        if (Reset) last_rise = -1;
        if (m_valid) begin
            chk("cpuButton", {31'd0, cpuButton}, {31'd0, m_cyc == m_press_at});
            chk("pressCount", {24'd0, pressCount}, m_cnt);
            if (cpuButton === 1'b1) begin
                if (last_rise >= 0) chk("spacing", {31'd0, (g_cyc - last_rise) >= CD + 1}, 1);
                last_rise = g_cyc;
            end
        end
    end
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic do_reset();
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
    endtask
    // Expects fresh reset release with difficulty all-ones, enable=1, gameOver=0.
    task automatic directed();
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("dir_btn_c%0d", i), {31'd0, cpuButton}, {31'd0, i == 5});
            if (i == 1) chk("dir_cnt_c1", {24'd0, pressCount}, 0);
            if (i >= 6) chk($sformatf("dir_cnt_c%0d", i), {24'd0, pressCount}, 1);
            step(1);
        end
    endtask
    task automatic wait_press(input int max, input string n);
        int k;
        for (k = 0; k < max; k++) begin
            if (cpuButton === 1'b1) break;
            step(1);
        end
        if (k == max) chk(n, 0, 1);
    endtask
    task automatic count_highs(input int n, output int c);
        c = 0;
        repeat (n) begin
            if (cpuButton === 1'b1) c++;
            step(1);
        end
    endtask
    int c;
    initial begin
        #1;
        enable = 1'b1;
        difficulty = 10'h3FF;
        step(2);
        do_reset();
        directed();
        difficulty = 10'h000;
        do_reset();
        count_highs(200, c);
        chk("diff0_presses", c, 0);
        chk("diff0_count", {24'd0, pressCount}, 0);
        difficulty = 10'h3FF;
        do_reset();
        step(2000);
        do_reset();
        wait_press(50, "go_wait1");
        gameOver = 1'b1;
        step(1);
        chk("go_pulse_one_cycle", {31'd0, cpuButton}, 0);
        count_highs(40, c);
        chk("go_blocked", c, 0);
        gameOver = 1'b0;
        wait_press(40, "go_resume");
        step(1);
        wait_press(40, "cool_wait");
        step(2);
        Reset = 1'b1;
        step(1);
        chk("rst_cool_btn", {31'd0, cpuButton}, 0);
        chk("rst_cool_cnt", {24'd0, pressCount}, 0);
        Reset = 1'b0;
        directed();
        do_reset();
        step(2500);
        chk("saturate", {24'd0, pressCount}, 255);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) difficulty = 10'($urandom);
            if ($urandom_range(31) == 0) enable = ~enable;
            if ($urandom_range(31) == 0) gameOver = ~gameOver;
            Reset = $urandom_range(499) == 0;
            step(1);
        end
        Reset = 1'b0;
        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
